// File: rtl/flow_vga_pkg.sv
// rtl/flow_vga_pkg.sv - shared screen geometry, state encoding and plot entry type for vga_plot_sink
package flow_vga_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int COLOR_W  = 15;
    localparam int ADDR_W   = 15;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;

    localparam logic [ADDR_W-1:0] LAST_ADDR = 15'd19199;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    typedef struct packed {
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [COLOR_W-1:0] color;
    } plot_entry_t;

    // y*160 + x as two shifts so no multiplier is needed
    function automatic logic [ADDR_W-1:0] pixel_addr(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        logic [ADDR_W-1:0] yw;
        yw = {8'd0, y};
        return (yw << 7) + (yw << 5) + {7'd0, x};
    endfunction

    function automatic logic in_range(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        return (x < 8'd160) && (y < 7'd120);
    endfunction

endpackage

// File: rtl/vga_plot_sink_if.sv
// rtl/vga_plot_sink_if.sv - plot request, clear control and framebuffer write signals of vga_plot_sink
interface vga_plot_sink_if;
    logic        plot;
    logic [7:0]  plot_x;
    logic [6:0]  plot_y;
    logic [14:0] plot_color;
    logic        plot_ready;
    logic        clear_req;
    logic        busy;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [14:0] mem_data;
    logic [15:0] drop_count;

    modport master (
        output plot, plot_x, plot_y, plot_color, clear_req,
        input  plot_ready, busy, mem_we, mem_addr, mem_data, drop_count
    );

    modport slave (
        input  plot, plot_x, plot_y, plot_color, clear_req,
        output plot_ready, busy, mem_we, mem_addr, mem_data, drop_count
    );
endinterface

// File: rtl/plot_fifo.sv
// rtl/plot_fifo.sv - synchronous show-ahead FIFO of plot entries with occupancy count
module plot_fifo
    import flow_vga_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  plot_entry_t              push_data,
    output plot_entry_t              pop_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    plot_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Caller guarantees no push when full and no pop when empty
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];
endmodule

// File: rtl/vga_plot_sink.sv
// rtl/vga_plot_sink.sv - plot FIFO to linear framebuffer writer with clear sweep; VGA_PLOT_DROP_COUNT_EN enables drop_count
module vga_plot_sink
    import flow_vga_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [14:0] CLEAR_COLOR = 15'h0000
) (
    input  logic            clock,
    input  logic            reset,
    vga_plot_sink_if.slave  bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic             plot_ready_q;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    plot_entry_t      push_entry;
    plot_entry_t      head;
    logic             push;
    logic             pop;
    logic             head_ok;
    logic             mem_we_q;
    logic [14:0]      mem_addr_q;
    logic [14:0]      mem_data_q;

    // A plot landing together with clear_req is swallowed by the flush
    assign push       = bus.plot && plot_ready_q && !bus.clear_req;
    assign pop        = (state != ST_CLEAR) && !bus.clear_req && (count != '0);
    assign push_entry = '{x: bus.plot_x, y: bus.plot_y, color: bus.plot_color};
    assign head_ok    = in_range(head.x, head.y);

    plot_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (bus.clear_req),
        .push      (push),
        .pop       (pop),
        .push_data (push_entry),
        .pop_data  (head),
        .count     (count)
    );

    always_comb begin
        count_next = count;
        if (bus.clear_req)
            count_next = '0;
        else
            count_next = count + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
    end

    always_comb begin
        state_next = ST_IDLE;
        if (bus.clear_req)
            state_next = ST_CLEAR;
        else if (state == ST_CLEAR && mem_addr_q != LAST_ADDR)
            state_next = ST_CLEAR;
        else if (count_next != '0)
            state_next = ST_DRAIN;
    end

    // During CLEAR the output address register doubles as the sweep counter
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            plot_ready_q <= 1'b1;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
        end else begin
            state        <= state_next;
            plot_ready_q <= (state_next != ST_CLEAR) && (count_next < CNT_W'(FIFO_DEPTH));
            if (bus.clear_req) begin
                mem_we_q   <= 1'b1;
                mem_addr_q <= '0;
                mem_data_q <= CLEAR_COLOR;
            end else if (state == ST_CLEAR) begin
                if (mem_addr_q == LAST_ADDR) begin
                    mem_we_q <= 1'b0;
                end else begin
                    mem_we_q   <= 1'b1;
                    mem_addr_q <= mem_addr_q + 15'd1;
                end
            end else if (pop && head_ok) begin
                mem_we_q   <= 1'b1;
                mem_addr_q <= pixel_addr(head.x, head.y);
                mem_data_q <= head.color;
            end else begin
                mem_we_q <= 1'b0;
            end
        end
    end

`ifdef VGA_PLOT_DROP_COUNT_EN
    logic [15:0] drop_q;

    always_ff @(posedge clock) begin
        if (reset)
            drop_q <= '0;
        else if (pop && !head_ok && drop_q != 16'hFFFF)
            drop_q <= drop_q + 16'd1;
    end

    assign bus.drop_count = drop_q;
`else
    assign bus.drop_count = '0;
`endif

    assign bus.plot_ready = plot_ready_q;
    assign bus.busy       = (state != ST_IDLE) || (count != '0) || mem_we_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_data   = mem_data_q;
endmodule

// File: tb/tb_vga_plot_sink.sv
// tb/tb_vga_plot_sink.sv - directed self-checking bench for vga_plot_sink
module tb_vga_plot_sink;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    vga_plot_sink_if bus();

    vga_plot_sink #(.FIFO_DEPTH(8), .CLEAR_COLOR(15'h0000)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

`ifdef VGA_PLOT_DROP_COUNT_EN
    localparam logic [31:0] EXP_DROP = 32'd2;
`else
    localparam logic [31:0] EXP_DROP = 32'd0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic        log_en = 1'b0;
    logic [14:0] log_addr[$];
    logic [14:0] log_data[$];

    always @(negedge clock) begin
        if (log_en && bus.mem_we === 1'b1) begin
            log_addr.push_back(bus.mem_addr);
            log_data.push_back(bus.mem_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic set_plot(input logic v, input logic [7:0] x, input logic [6:0] y, input logic [14:0] c);
        bus.plot       = v;
        bus.plot_x     = x;
        bus.plot_y     = y;
        bus.plot_color = c;
    endtask

    task automatic plot_scenario(input string tag, input logic [7:0] x, input logic [6:0] y,
                                 input logic [14:0] c, input logic [14:0] exp_addr);
        set_plot(1'b1, x, y, c);
        check({tag, "_ready"}, 32'(bus.plot_ready), 32'd1);
        step(1);
        set_plot(1'b0, 8'd0, 7'd0, 15'd0);
        check({tag, "_n1_we"}, 32'(bus.mem_we), 32'd0);
        check({tag, "_n1_busy"}, 32'(bus.busy), 32'd1);
        step(1);
        check({tag, "_n2_we"}, 32'(bus.mem_we), 32'd1);
        check({tag, "_n2_addr"}, 32'(bus.mem_addr), 32'(exp_addr));
        check({tag, "_n2_data"}, 32'(bus.mem_data), 32'(c));
        step(1);
        check({tag, "_n3_we"}, 32'(bus.mem_we), 32'd0);
        check({tag, "_n3_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int bad;
        int acc;
        int i;
        int guard;

        reset         = 1'b1;
        bus.clear_req = 1'b0;
        set_plot(1'b0, 8'd0, 7'd0, 15'd0);
        step(3);
        check("rst_ready", 32'(bus.plot_ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_we", 32'(bus.mem_we), 32'd0);
        check("rst_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_data", 32'(bus.mem_data), 32'd0);
        check("rst_drop", 32'(bus.drop_count), 32'd0);
        reset = 1'b0;
        step(1);

        plot_scenario("p1", 8'd5, 7'd2, 15'h7C00, 15'd325);

        // bounds: corner pixel written, x=160 and y=120 dropped
        step(1);
        set_plot(1'b1, 8'd159, 7'd119, 15'h1234);
        step(1);
        set_plot(1'b1, 8'd160, 7'd0, 15'h2222);
        check("bnd_m1_we", 32'(bus.mem_we), 32'd0);
        step(1);
        set_plot(1'b1, 8'd0, 7'd120, 15'h3333);
        check("bnd_m2_we", 32'(bus.mem_we), 32'd1);
        check("bnd_m2_addr", 32'(bus.mem_addr), 32'd19199);
        check("bnd_m2_data", 32'(bus.mem_data), 32'h1234);
        step(1);
        set_plot(1'b0, 8'd0, 7'd0, 15'd0);
        check("bnd_m3_we", 32'(bus.mem_we), 32'd0);
        step(1);
        check("bnd_m4_we", 32'(bus.mem_we), 32'd0);
        check("bnd_m4_addr_hold", 32'(bus.mem_addr), 32'd19199);
        step(1);
        check("bnd_drop", 32'(bus.drop_count), EXP_DROP);
        check("bnd_busy", 32'(bus.busy), 32'd0);

        // clear with a simultaneous plot, then 10 plots held off by the sweep
        step(1);
        bus.clear_req = 1'b1;
        set_plot(1'b1, 8'd1, 7'd1, 15'h7FFF);
        step(1);
        bus.clear_req = 1'b0;
        set_plot(1'b1, 8'd10, 7'd20, 15'h0100);
        check("clr_first_we", 32'(bus.mem_we), 32'd1);
        check("clr_first_addr", 32'(bus.mem_addr), 32'd0);
        bad = 0;
        for (int k = 0; k < 19200; k++) begin
            if (!(bus.mem_we === 1'b1 && bus.mem_addr === k[14:0] && bus.mem_data === 15'h0000 &&
                  bus.plot_ready === 1'b0 && bus.busy === 1'b1))
                bad++;
            step(1);
        end
        check("clr_bad_cycles", 32'(bad), 32'd0);
        check("clr_after_we", 32'(bus.mem_we), 32'd0);
        check("clr_after_ready", 32'(bus.plot_ready), 32'd1);
        check("clr_after_busy", 32'(bus.busy), 32'd0);

        log_en = 1'b1;
        i      = 0;
        guard  = 0;
        while (i < 10 && guard < 200) begin
            acc = int'(bus.plot_ready);
            @(posedge clock);
            #1;
            if (acc == 1) begin
                i++;
                if (i < 10)
                    set_plot(1'b1, 8'(10 + i), 7'(20 + i), 15'(15'h0100 + i));
                else
                    set_plot(1'b0, 8'd0, 7'd0, 15'd0);
            end
            guard++;
            @(negedge clock);
        end
        check("q_accepted", 32'(i), 32'd10);
        step(6);
        log_en = 1'b0;
        check("q_writes", 32'(log_addr.size()), 32'd10);
        for (int j = 0; j < 10 && j < log_addr.size(); j++) begin
            check($sformatf("q_addr%0d", j), 32'(log_addr[j]), 32'(3210 + 161 * j));
            check($sformatf("q_data%0d", j), 32'(log_data[j]), 32'(32'h100 + j));
        end

        // restart mid-sweep, then reset at address 1000
        bus.clear_req = 1'b1;
        step(1);
        bus.clear_req = 1'b0;
        step(500);
        check("rs_addr500", 32'(bus.mem_addr), 32'd500);
        bus.clear_req = 1'b1;
        step(1);
        bus.clear_req = 1'b0;
        check("rs_restart_addr", 32'(bus.mem_addr), 32'd0);
        check("rs_restart_we", 32'(bus.mem_we), 32'd1);
        step(1000);
        check("rs_addr1000", 32'(bus.mem_addr), 32'd1000);
        reset = 1'b1;
        step(1);
        check("rs_we", 32'(bus.mem_we), 32'd0);
        check("rs_ready", 32'(bus.plot_ready), 32'd1);
        check("rs_busy", 32'(bus.busy), 32'd0);
        check("rs_drop", 32'(bus.drop_count), 32'd0);
        reset = 1'b0;
        step(1);

        plot_scenario("p2", 8'd5, 7'd2, 15'h7C00, 15'd325);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vga_plot_sink.md
Name: vga_plot_sink

Overview:
Consumer end of the flow core's pixel-plot interface (x, y, color, plot). Buffers plot requests in a small FIFO, bounds-checks them, and converts each to a linear framebuffer write on a single-port write interface. Also runs a full-screen clear sequencer on request. Sits between the flow core and the VGA adapter's framebuffer RAM in the FPGA top level.

Parameters:
FIFO_DEPTH, 8, plot-request FIFO entries; power of two, minimum 2.
CLEAR_COLOR, 15'h0000, 15-bit RGB555 value written by the clear sweep.

Ports:
clock  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high reset
plot  in  1  plot request valid
plot_x  in  8  pixel column, 0..159 valid
plot_y  in  7  pixel row, 0..119 valid
plot_color  in  15  RGB555 colour
plot_ready  out  1  request accepted when plot && plot_ready
clear_req  in  1  single-cycle pulse; start a full-screen clear
busy  out  1  high while clearing or while the FIFO is non-empty
mem_we  out  1  framebuffer write strobe; the RAM accepts one write per cycle
mem_addr  out  15  linear address, y*160 + x
mem_data  out  15  colour to write
drop_count  out  16  saturating count of out-of-range plots (see Optional Feature)

Behaviour:
- Reset: state IDLE, FIFO empty, plot_ready=1, busy=0, mem_we=0, mem_addr=0, mem_data=0, drop_count=0.
- States:
  - IDLE: FIFO empty, not clearing.
  - DRAIN: FIFO non-empty; pops one entry per cycle.
  - CLEAR: sweeping the framebuffer.
- plot_ready is a registered output: 1 iff state != CLEAR and FIFO count < FIFO_DEPTH, evaluated for the next cycle.
  - A push and a pop in the same cycle keep the count unchanged.
  - When the FIFO is full, a simultaneous pop does not raise plot_ready in that same cycle.
- Pop path:
  - The popped entry is registered to the memory port one cycle later.
  - A plot accepted into an empty FIFO in cycle N produces mem_we=1 in cycle N+2.
  - Back-to-back accepted plots produce back-to-back writes in order.
- Address computation: mem_addr = (y<<7) + (y<<5) + x, computed at 15 bits, no truncation (max 19199).
- Bounds check at pop: an entry with x >= 160 or y >= 120 produces no write (mem_we=0 that cycle) and increments drop_count.
- CLEAR sequence:
  - On clear_req, go to CLEAR the next cycle and flush the FIFO.
  - A plot accepted in the same cycle as clear_req is discarded.
  - Write CLEAR_COLOR at addresses 0,1,...,19199, one per cycle, with mem_we=1 continuously (19200 cycles).
  - After address 19199, return to IDLE with plot_ready=1 on the following cycle.
- clear_req during CLEAR restarts the sweep at address 0.
- busy = (state != IDLE) or FIFO non-empty or a write is pending in the output register.
- mem_we is low in every cycle without a valid write. mem_addr and mem_data hold their last values when mem_we=0.
- reset asserted mid-CLEAR or mid-DRAIN aborts immediately:
  - outputs return to their reset values on the next edge;
  - FIFO contents are lost.

Optional Feature:
VGA_PLOT_DROP_COUNT_EN
- Defined: drop_count is a 16-bit counter that increments on each out-of-range pop and saturates at 16'hFFFF. Cleared by reset only; not cleared by CLEAR.
- Undefined: drop_count is tied to 0 and no counter logic is synthesised. Out-of-range entries are still dropped silently.

Decomposition:
- Package flow_vga_pkg holds:
  - SCREEN_W=160, SCREEN_H=120;
  - COLOR_W=15, ADDR_W=15, X_W=8, Y_W=7;
  - LAST_ADDR=19199;
  - the state encoding (IDLE, DRAIN, CLEAR).
- Sub-module plot_fifo: synchronous FIFO, width 30 ({x,y,color}), depth FIFO_DEPTH, with count output; full/empty derived from count.
- Bounds check, address arithmetic and the clear sequencer stay in vga_plot_sink.

Test Plan:
- Reset, then plot (x=5, y=2, color=15'h7C00) in cycle N -> in cycle N+2: mem_we=1, mem_addr=325, mem_data=15'h7C00; busy falls one cycle after the write.
- 10 plots offered back-to-back with depth 8 and the output path blocked by an in-progress CLEAR -> plot_ready=0 throughout; no plot is accepted. After the clear ends, all 10 are accepted and written in order with correct addresses.
- Plots (159,119) and (160,0) then (0,120) -> one write at addr 19199; the other two produce no mem_we; drop_count=2 with VGA_PLOT_DROP_COUNT_EN defined, 0 without.
- clear_req pulse -> exactly 19200 consecutive mem_we cycles, addr 0..19199, data=CLEAR_COLOR; plot_ready=0 throughout and 1 the cycle after.
- clear_req in the same cycle as an accepted plot, with 3 entries queued -> none of the queued or simultaneous plots is written; the clear sweep starts at addr 0.
- reset asserted at clear address 1000 -> next cycle mem_we=0, plot_ready=1, busy=0; a subsequent plot behaves as in the first scenario.
